// File: rtl/serpent_subkey_bank_pkg.sv
// Shared constants and fill-state encoding for the Serpent subkey path.
// Used by the key schedule, the subkey bank and the round engine.
package serpent_subkey_bank_pkg;

    localparam int NUM_SUBKEYS = 33;
    localparam int SUBKEY_W    = 128;
    localparam int ADDR_W      = 6;
    localparam int CNT_W       = $clog2(NUM_SUBKEYS + 1);

    // First illegal address and the full-set count, at their native widths.
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_SUBKEYS);
    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(NUM_SUBKEYS);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        READY   = 2'd2
    } fill_state_t;

endpackage

// File: rtl/serpent_subkey_ram.sv
// NUM_SUBKEYS x SUBKEY_W storage: one write port and one registered read port.
// Contents are not reset; the read register only updates on a read request,
// so it holds its last value between reads.
module serpent_subkey_ram
    import serpent_subkey_bank_pkg::*;
(
    input  logic                clk,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [SUBKEY_W-1:0] wr_data,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [SUBKEY_W-1:0] rd_data
);

    logic [SUBKEY_W-1:0] mem [NUM_SUBKEYS];

    // Write and registered read; a same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/serpent_subkey_bank.sv
// Subkey bank: captures the 33 round subkeys from the key schedule, tracks
// which indices have been seen since the last i_begin, and serves reads once
// the set is complete.
// Optional build macro SUBKEY_BANK_DBUF_EN: active/shadow double buffering so
// reads keep being served from the previous complete set during a refill.
//
// Handshake: i_subkey_valid and i_rd_en are single-cycle strobes with no
// backpressure; o_rd_valid marks o_rd_data exactly one cycle after an
// accepted read. o_state exposes the fill FSM for observation.
module serpent_subkey_bank
    import serpent_subkey_bank_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_begin,
    input  logic [SUBKEY_W-1:0] i_subkey,
    input  logic [ADDR_W-1:0]   i_address,
    input  logic                i_subkey_valid,
    input  logic                i_rd_en,
    input  logic [ADDR_W-1:0]   i_rd_addr,
    output logic [SUBKEY_W-1:0] o_rd_data,
    output logic                o_rd_valid,
    output logic                o_ready,
    output logic                o_error,
    output logic [1:0]          o_state
);

    fill_state_t            state_q;
    logic [NUM_SUBKEYS-1:0] mask_q, base_mask, mask_n;
    logic [CNT_W-1:0]       cnt_q, base_cnt, cnt_n;
    logic                   fill_active, wr_in_range, wr_en, wr_bad, new_bit;
    logic                   fill_done, rd_accept, rd_in_range, ram_re;
    logic                   rd_zero_q;

    assign o_state = state_q;

    // Fill bookkeeping: i_begin restarts the mask before this cycle's write lands.
    always_comb begin
        fill_active = i_begin || (state_q == FILLING);
        wr_in_range = (i_address < ADDR_LIMIT);
        wr_en       = i_subkey_valid && fill_active && wr_in_range;
        wr_bad      = i_subkey_valid && fill_active && !wr_in_range;
        base_mask   = i_begin ? '0 : mask_q;
        base_cnt    = i_begin ? '0 : cnt_q;
        new_bit     = wr_en && !base_mask[i_address];
        mask_n      = base_mask;
        if (new_bit) begin
            mask_n[i_address] = 1'b1;
        end
        cnt_n       = base_cnt + CNT_W'(new_bit);
        fill_done   = fill_active && (cnt_n == CNT_FULL);
        rd_accept   = i_rd_en && o_ready;
        rd_in_range = (i_rd_addr < ADDR_LIMIT);
        ram_re      = rd_accept && rd_in_range;
    end

`ifdef SUBKEY_BANK_DBUF_EN
    logic                act_q;
    logic                act_valid_q;
    logic                rd_bank_q;
    logic [SUBKEY_W-1:0] rdata0, rdata1;

    // Bank 0 is the shadow while bank 1 is active, and vice versa.
    serpent_subkey_ram u_ram0 (
        .clk     (i_clk),
        .wr_en   (wr_en && act_q),
        .wr_addr (i_address),
        .wr_data (i_subkey),
        .rd_en   (ram_re && !act_q),
        .rd_addr (i_rd_addr),
        .rd_data (rdata0)
    );

    serpent_subkey_ram u_ram1 (
        .clk     (i_clk),
        .wr_en   (wr_en && !act_q),
        .wr_addr (i_address),
        .wr_data (i_subkey),
        .rd_en   (ram_re && act_q),
        .rd_addr (i_rd_addr),
        .rd_data (rdata1)
    );

    assign o_rd_data = rd_zero_q ? '0 : (rd_bank_q ? rdata1 : rdata0);
`else
    logic [SUBKEY_W-1:0] ram_rdata;

    serpent_subkey_ram u_ram (
        .clk     (i_clk),
        .wr_en   (wr_en),
        .wr_addr (i_address),
        .wr_data (i_subkey),
        .rd_en   (ram_re),
        .rd_addr (i_rd_addr),
        .rd_data (ram_rdata)
    );

    assign o_rd_data = rd_zero_q ? '0 : ram_rdata;
`endif

    // Fill FSM with its registered status and read-side outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q     <= EMPTY;
            mask_q      <= '0;
            cnt_q       <= '0;
            o_ready     <= 1'b0;
            o_error     <= 1'b0;
            o_rd_valid  <= 1'b0;
            rd_zero_q   <= 1'b1;
`ifdef SUBKEY_BANK_DBUF_EN
            act_q       <= 1'b0;
            act_valid_q <= 1'b0;
            rd_bank_q   <= 1'b0;
`endif
        end else begin
            o_rd_valid <= rd_accept;
            if (rd_accept) begin
                rd_zero_q <= !rd_in_range;
            end
            if (fill_active) begin
                mask_q <= mask_n;
                cnt_q  <= cnt_n;
            end
            o_error <= (o_error && !i_begin) || wr_bad || (rd_accept && !rd_in_range);
            if (fill_done) begin
                state_q <= READY;
            end else if (fill_active) begin
                state_q <= FILLING;
            end
`ifdef SUBKEY_BANK_DBUF_EN
            if (rd_accept) begin
                rd_bank_q <= act_q;
            end
            if (fill_done) begin
                act_q       <= !act_q;
                act_valid_q <= 1'b1;
            end
            o_ready <= act_valid_q || fill_done;
`else
            o_ready <= fill_done || (o_ready && !i_begin);
`endif
        end
    end

endmodule
